// File: rtl/dio_slot_arbiter.sv
// Round-robin owner of the DIO memory slot: one disk/DMA reader per slot, drives
// the slot's memory address and read enable, and acks at slot end when data is valid.
module dio_slot_arbiter #(
    parameter int NREQ = 4,
    parameter int ADDR_W = 22,
    parameter logic [NREQ*ADDR_W-1:0] BASES = {22'h300000, 22'h280000, 22'h200000, 22'h100000}
) (
    input  logic                     clk,
    input  logic                     _reset,
    input  logic                     cep,
    input  logic                     dioBusControl,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*ADDR_W-1:0]   reqAddr,
    output logic [NREQ-1:0]          ack,
    output logic [ADDR_W-1:0]        memoryAddr,
    output logic                     _dioOE,
    output logic                     grantValid,
    output logic [2:0]               grantIdx
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t            state, nextState;
    logic              dioPrev;
    logic              slotStart, slotEnd;
    logic [2:0]        rrPtr, nextRr, pick, cand;
    logic              anyReq;
    logic [7:0]        reqPad;
    logic [ADDR_W-1:0] pickAddr, nextAddr;
    logic              nextValid, nextOE;
    logic [2:0]        nextIdx;

    assign slotStart = dioBusControl & ~dioPrev;
    assign slotEnd   = dioBusControl & cep;
    assign reqPad    = 8'(req);

    // Scan downward from the farthest offset so the nearest request at/after rrPtr wins.
    always_comb begin
        anyReq = 1'b0;
        pick   = '0;
        cand   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = 3'((int'(rrPtr) + i) % NREQ);
            if (reqPad[cand]) begin
                anyReq = 1'b1;
                pick   = cand;
            end
        end
    end

    always_comb begin
        pickAddr = '0;
        for (int g = 0; g < NREQ; g++) begin
            if (pick == 3'(g))
                pickAddr = BASES[g*ADDR_W +: ADDR_W] + reqAddr[g*ADDR_W +: ADDR_W];
        end
    end

    always_comb begin
        nextState = state;
        nextValid = grantValid;
        nextOE    = _dioOE;
        nextIdx   = grantIdx;
        nextAddr  = memoryAddr;
        nextRr    = rrPtr;
        case (state)
            IDLE: begin
                if (slotStart && anyReq) begin
                    nextState = GRANT;
                    nextValid = 1'b1;
                    nextOE    = 1'b0;
                    nextIdx   = pick;
                    nextAddr  = pickAddr;
                end
            end
            GRANT: begin
                if (!dioBusControl || cep) begin
                    // Malformed slot (bus dropped without cep) leaves the pointer alone.
                    nextState = IDLE;
                    nextValid = 1'b0;
                    nextOE    = 1'b1;
                    nextAddr  = '0;
                    if (dioBusControl)
                        nextRr = (grantIdx == 3'(NREQ - 1)) ? 3'd0 : grantIdx + 3'd1;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state      <= IDLE;
            dioPrev    <= 1'b1;  // a slot already in flight at release must not count as a start
            rrPtr      <= '0;
            grantValid <= 1'b0;
            _dioOE     <= 1'b1;
            grantIdx   <= '0;
            memoryAddr <= '0;
        end else begin
            state      <= nextState;
            dioPrev    <= dioBusControl;
            rrPtr      <= nextRr;
            grantValid <= nextValid;
            _dioOE     <= nextOE;
            grantIdx   <= nextIdx;
            memoryAddr <= nextAddr;
        end
    end

    assign ack = (state == GRANT && slotEnd && reqPad[grantIdx]) ? NREQ'(8'd1 << grantIdx) : '0;

endmodule

// File: tb/tb_dio_slot_arbiter.sv
// Directed bench for dio_slot_arbiter: stimulus pushes expected grants/acks, a
// negedge monitor pops and compares whenever the DUT grants or acks.
module tb_dio_slot_arbiter;

    localparam int NREQ = 4;
    localparam int AW = 22;

    logic              clk;
    logic              _reset;
    logic              cep;
    logic              dioBusControl;
    logic [NREQ-1:0]   req;
    logic [NREQ*AW-1:0] reqAddr;
    logic [NREQ-1:0]   ack;
    logic [AW-1:0]     memoryAddr;
    logic              _dioOE;
    logic              grantValid;
    logic [2:0]        grantIdx;

    dio_slot_arbiter #(.NREQ(NREQ), .ADDR_W(AW)) dut (
        .clk(clk), ._reset(_reset), .cep(cep), .dioBusControl(dioBusControl),
        .req(req), .reqAddr(reqAddr), .ack(ack), .memoryAddr(memoryAddr),
        ._dioOE(_dioOE), .grantValid(grantValid), .grantIdx(grantIdx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [AW-1:0] addr;
    } ackExp_t;

    int      total = 0;
    int      bad = 0;
    int      grantQ[$];
    ackExp_t ackQ[$];
    logic    gvPrev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic expectAck(input int idx, input logic [AW-1:0] addr);
        ackExp_t e;
        e.idx = idx;
        e.addr = addr;
        grantQ.push_back(idx);
        ackQ.push_back(e);
    endtask

    always @(negedge clk) begin
        if (grantValid && !gvPrev) begin
            if (grantQ.size() == 0) chk("unexpected_grant", {29'd0, grantIdx}, 32'hFFFFFFFF);
            else chk("grant_idx", {29'd0, grantIdx}, grantQ.pop_front());
        end
        if (ack != '0) begin
            chk("ack_onehot_with_grant", {30'd0, grantValid, ($countones(ack) == 1)}, 32'd3);
            if (ackQ.size() == 0) chk("unexpected_ack", {28'd0, ack}, 32'd0);
            else begin
                ackExp_t e;
                e = ackQ.pop_front();
                chk("ack_bit", {28'd0, ack}, 32'(4'd1 << e.idx));
                chk("ack_addr", {10'd0, memoryAddr}, {10'd0, e.addr});
                chk("ack_oe", {31'd0, _dioOE}, 32'd0);
            end
        end
        gvPrev = grantValid;
    end

    // One DIO slot: dio high for len clks, cep on the last one unless aborting.
    // dropMask clears and lateMask sets request bits one clk into the slot.
    task automatic slot(input int len, input bit withEnd,
                        input logic [NREQ-1:0] dropMask, input logic [NREQ-1:0] lateMask);
        dioBusControl = 1'b1;
        cep = 1'b0;
        for (int k = 0; k < len; k++) begin
            if (k == 1) req = (req & ~dropMask) | lateMask;
            if (k == len - 1) cep = withEnd;
            @(posedge clk); #1;
        end
        dioBusControl = 1'b0;
        cep = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
    endtask

    initial begin
        _reset = 1'b0;
        cep = 1'b0;
        dioBusControl = 1'b0;
        req = '0;
        reqAddr = '0;
        reqAddr[0*AW +: AW] = 22'h000010;
        reqAddr[1*AW +: AW] = 22'h000020;
        reqAddr[2*AW +: AW] = 22'h000030;
        reqAddr[3*AW +: AW] = 22'h000040;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", {28'd0, ack}, 32'd0);
        chk("rst_addr", {10'd0, memoryAddr}, 32'd0);
        chk("rst_oe", {31'd0, _dioOE}, 32'd1);
        chk("rst_gv", {31'd0, grantValid}, 32'd0);
        chk("rst_idx", {29'd0, grantIdx}, 32'd0);
        _reset = 1'b1;
        repeat (2) begin @(posedge clk); #1; end

        // all four requesting for 8 slots: strict rotation from pointer 0
        req = 4'b1111;
        for (int s = 0; s < 8; s++) begin
            case (s % 4)
                0: expectAck(0, 22'h100010);
                1: expectAck(1, 22'h200020);
                2: expectAck(2, 22'h280030);
                default: expectAck(3, 22'h300040);
            endcase
            slot(4, 1'b1, '0, '0);
        end

        // single requester 0
        req = 4'b0001;
        expectAck(0, 22'h100010);
        slot(4, 1'b1, '0, '0);
        chk("idle_oe_after_slot", {31'd0, _dioOE}, 32'd1);
        chk("idle_addr_after_slot", {10'd0, memoryAddr}, 32'd0);

        // req1 withdrawn while granted: slot consumed, no ack, pointer moves to 2
        req = 4'b0110;
        grantQ.push_back(1);
        slot(4, 1'b1, 4'b0010, '0);
        expectAck(2, 22'h280030);
        slot(4, 1'b1, '0, '0);

        // address wrap on requester 3
        req = 4'b1000;
        reqAddr[3*AW +: AW] = 22'h3FFFFF;
        expectAck(3, 22'h2FFFFF);
        slot(4, 1'b1, '0, '0);

        // request raised mid-slot waits for the next slot start
        req = 4'b0000;
        slot(4, 1'b1, '0, 4'b0010);
        chk("late_req_no_grant", {31'd0, grantValid}, 32'd0);
        expectAck(1, 22'h200020);
        slot(4, 1'b1, '0, '0);

        // bus drops without cep: no ack, pointer stays at 2
        req = 4'b0001;
        grantQ.push_back(0);
        slot(4, 1'b0, '0, '0);
        req = 4'b1111;
        expectAck(2, 22'h280030);
        slot(4, 1'b1, '0, '0);

        // reset mid-grant: outputs clear without a clock, pointer back to 0
        grantQ.push_back(3);
        dioBusControl = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("pre_rst_gv", {31'd0, grantValid}, 32'd1);
        _reset = 1'b0;
        #1;
        chk("async_rst_oe", {31'd0, _dioOE}, 32'd1);
        chk("async_rst_gv", {31'd0, grantValid}, 32'd0);
        chk("async_rst_addr", {10'd0, memoryAddr}, 32'd0);
        @(posedge clk);
        #1;
        _reset = 1'b1;
        @(posedge clk); #1;
        cep = 1'b1;
        @(posedge clk); #1;
        chk("no_grant_after_rst_release", {31'd0, grantValid}, 32'd0);
        dioBusControl = 1'b0;
        cep = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        expectAck(0, 22'h100010);
        slot(4, 1'b1, '0, '0);

        chk("grantQ_drained", grantQ.size(), 32'd0);
        chk("ackQ_drained", ackQ.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
